spi_tick_master: RTL
====================

// Module: spi_tick_master
// PURPOSE
// Downstream consumer of the 100 kHz -> 1 Hz divider output. Synchronises the slow
// square wave (tick_in) into the clk_in domain and detects its rising edge. On each
// edge, runs one SPI mode-0 master frame: tx_data out on mosi MSB-first, miso captured
// into rx_data. Reports frame completion, busy, dropped ticks and a completed-frame count.
// PARAMETERS
// DATA_W    8   bits per SPI frame (>=1)
// SCLK_DIV  4   clk_in cycles per SCLK half-period (>=1)
// PORTS
// clk_in     in   1       system clock; all logic on posedge
// rst_n      in   1       asynchronous active-low reset
// tick_in    in   1       divider clk_out, asynchronous to clk_in
// tx_data    in   DATA_W  word to send; sampled on the cycle the frame starts
// miso       in   1       SPI slave data in
// sclk       out  1       SPI clock, idle low (CPOL=0, CPHA=0)
// mosi       out  1       SPI data out
// cs_n       out  1       SPI chip select, active low
// busy       out  1       high from frame start until cs_n returns high
// rx_data    out  DATA_W  last received word; updates only at frame end
// rx_valid   out  1       one-cycle pulse when rx_data updates
// overrun    out  1       sticky: a tick edge arrived while busy; cleared only by reset
// frame_cnt  out  16      completed frames, wraps 0xFFFF -> 0x0000
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, sclk=0, mosi=0, cs_n=1, busy=0, rx_data=0,
//   rx_valid=0, overrun=0, frame_cnt=0, sync flops s1/s2/s3=0, half-period counter hc=0.
// - Sync: s1<=tick_in, s2<=s1, s3<=s2; start = s2 & ~s3 (combinational).
//   If tick_in is high at reset release, this is a rising edge and starts a frame.
// - Latency: tick_in rises before clk edge E1 -> s1=1 at E1, s2=1 at E2, cs_n=0 at E3.
// - hc counts 0..SCLK_DIV-1 in SETUP/SHIFT/HOLD; "half-end" = hc==SCLK_DIV-1; hc resets
//   to 0 on every state entry and at each half-end.
// - FSM:
//   IDLE : start -> shift_reg<=tx_data, mosi<=tx_data[DATA_W-1], cs_n<=0, busy<=1, ->SETUP.
//   SETUP: half-end -> sclk<=1 (rising edge 1), rx_shift<={rx_shift,miso}, ->SHIFT.
//   SHIFT: at half-end toggle sclk. Rising: shift miso into rx_shift LSB.
//          Falling after rising edge k<DATA_W: mosi<=next bit. Falling after rising
//          edge DATA_W: sclk<=0, ->HOLD (mosi holds).
//   HOLD : half-end -> cs_n<=1, busy<=0, rx_data<=rx_shift, rx_valid<=1, frame_cnt+1, ->IDLE.
// - Frame timing relative to cs_n fall (cycle 0): rising edges at SCLK_DIV*(2k+1),
//   falling at SCLK_DIV*(2k+2), k=0..DATA_W-1; cs_n low exactly SCLK_DIV*(2*DATA_W+1)
//   cycles (68 at defaults). Exactly DATA_W sclk rising edges per frame.
// - mosi changes only while sclk is low or at cs_n fall; miso is sampled only on sclk rising.
// - start while busy (any non-IDLE state, including the HOLD half-end cycle): tick dropped,
//   overrun<=1, frame unaffected. start never queues.
// - rx_valid is high for exactly one cycle per completed frame. Earliest next start: the
//   cycle after rx_valid (state IDLE).
// - Reset mid-frame: frame aborted immediately; no rx_valid; frame_cnt not incremented
//   (returns to 0); cs_n=1 and sclk=0 asynchronously.
// - tx_data changes after the start cycle do not affect the frame in progress.
// TESTING
// 1. Defaults, tx_data=0xA5, miso looped to mosi, one tick_in rise -> cs_n falls 3 clks
//    later, low 68 clks, 8 sclk rises, mosi=1,0,1,0,0,1,0,1; rx_data=0xA5, rx_valid 1 clk,
//    frame_cnt=1.
// 2. tx_data=0x00, miso tied 1 -> mosi low all frame, rx_data=0xFF; tx_data changed to 0xFF
//    mid-frame has no effect.
// 3. Second tick_in rise 20 clks after cs_n fall -> one frame only, overrun=1 and stays 1;
//    next tick after busy=0 starts a normal frame, frame_cnt=2.
// 4. rst_n low at 30 clks after cs_n fall -> cs_n=1, sclk=0, busy=0 immediately, no rx_valid,
//    frame_cnt=0; next tick after release runs a full frame.
// 5. tick_in held high across reset release -> frame starts (cs_n=0 3 clks after release).
// 6. DATA_W=1, SCLK_DIV=1, 65536 ticks -> frame_cnt wraps to 0x0000; cs_n low 3 clks per frame.

Source files
------------

// File: rtl/spi_tick_master.sv
// spi_tick_master: synchronises a slow asynchronous tick and runs one SPI
// mode-0 master frame (MSB-first) per rising edge of that tick.
//
// Ports:
//   i_clk_in    system clock, all logic on posedge
//   i_rst_n     asynchronous active-low reset
//   i_tick_in   slow square wave, asynchronous to i_clk_in
//   i_tx_data   word to send, sampled on the frame start cycle
//   i_miso      SPI slave data in, sampled on sclk rising edges
//   o_sclk      SPI clock, idle low
//   o_mosi      SPI data out, changes only while sclk is low
//   o_cs_n      SPI chip select, active low
//   o_busy      high from frame start until cs_n returns high
//   o_rx_data   last received word, updated at frame end
//   o_rx_valid  one-cycle pulse when o_rx_data updates
//   o_overrun   sticky flag: a tick edge arrived while a frame was running
//   o_frame_cnt completed-frame counter, wraps at 16 bits
module spi_tick_master #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic              i_clk_in,
    input  logic              i_rst_n,
    input  logic              i_tick_in,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_overrun,
    output logic [15:0]       o_frame_cnt
);

    localparam int unsigned HC_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BC_W = $clog2(DATA_W + 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t              r_state;
    logic                r_s1;
    logic                r_s2;
    logic                r_s3;
    logic [HC_W-1:0]     r_hc;
    logic [BC_W-1:0]     r_bc;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_cs_n;
    logic                r_busy;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_overrun;
    logic [15:0]         r_frame_cnt;

    logic                w_start;
    logic                w_half_end;
    logic [DATA_W-1:0]   w_tx_next;
    logic [DATA_W-1:0]   w_rx_next;

    assign w_start    = r_s2 & ~r_s3;
    assign w_half_end = (r_hc == HC_LAST);
    // Shift-based forms stay legal when DATA_W is 1.
    assign w_tx_next  = r_tx_shift << 1;
    assign w_rx_next  = (r_rx_shift << 1) | DATA_W'(i_miso);

    // Three-flop synchroniser; s3 delays s2 for rising-edge detection.
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Frame sequencer with registered SPI outputs.
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_hc        <= '0;
            r_bc        <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            // Ticks never queue: any edge outside IDLE is dropped and flagged.
            if (w_start && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_tx_shift <= i_tx_data;
                        r_mosi     <= i_tx_data[DATA_W-1];
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_hc       <= '0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_half_end) begin
                        r_hc       <= '0;
                        r_sclk     <= 1'b1;
                        r_rx_shift <= w_rx_next;
                        r_bc       <= BC_W'(1);
                        r_state    <= ST_SHIFT;
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_half_end) begin
                        r_hc <= '0;
                        if (!r_sclk) begin
                            r_sclk     <= 1'b1;
                            r_rx_shift <= w_rx_next;
                            r_bc       <= r_bc + 1'b1;
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bc == BC_LAST) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_tx_shift <= w_tx_next;
                                r_mosi     <= w_tx_next[DATA_W-1];
                            end
                        end
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_half_end) begin
                        r_hc        <= '0;
                        r_cs_n      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_rx_data   <= r_rx_shift;
                        r_rx_valid  <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_hc <= r_hc + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sclk      = r_sclk;
    assign o_mosi      = r_mosi;
    assign o_cs_n      = r_cs_n;
    assign o_busy      = r_busy;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_overrun   = r_overrun;
    assign o_frame_cnt = r_frame_cnt;

endmodule
